// File: rtl/gcd_lcm_pkg.sv
// Shared types and constants for the GCD/LCM coprocessor: FSM states, op encoding,
// operand-word field positions and a saturating increment helper.
package gcd_lcm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN_GCD,
    RUN_LCM,
    DONE
  } state_t;

  localparam logic OP_GCD = 1'b0;
  localparam logic OP_LCM = 1'b1;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;

  // Operand word layout: A in the low field, B directly above it, op bit above B.
  localparam int unsigned A_LSB = 0;

  function automatic int unsigned b_lsb(input int unsigned data_w);
    return A_LSB + data_w;
  endfunction

  function automatic int unsigned op_bit(input int unsigned data_w);
    return A_LSB + 2 * data_w;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/gcd_lcm_step.sv
// One combinational iteration of the subtractive GCD / additive LCM loop.
// GCD shrinks the larger of the pair; LCM grows the smaller multiple by its base.
module gcd_lcm_step
  import gcd_lcm_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                  op,
  input  logic [2*DATA_W-1:0]   p0,
  input  logic [2*DATA_W-1:0]   p1,
  input  logic [2*DATA_W-1:0]   a,
  input  logic [2*DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0]   n0,
  output logic [2*DATA_W-1:0]   n1,
  output logic                  eq
);

  always_comb begin
    n0 = p0;
    n1 = p1;
    eq = (p0 == p1);
    if (!eq) begin
      if (op == OP_GCD) begin
        if (p0 > p1) n0 = p0 - p1;
        else         n1 = p1 - p0;
      end else begin
        if (p0 < p1) n0 = p0 + a;
        else         n1 = p1 + b;
      end
    end
  end

endmodule

// File: rtl/gcd_lcm_coproc.sv
// Iterative GCD/LCM coprocessor top: FSM, operand/pair/result registers.
// Optional RUN-cycle counter output enabled by defining GCD_LCM_CYCLE_COUNT_EN.
module gcd_lcm_coproc
  import gcd_lcm_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] wd_in,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result
`ifdef GCD_LCM_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0]  cycles
`endif
);

  localparam int unsigned RW = 2 * DATA_W;

  state_t state, state_nxt;

  logic [DATA_W-1:0] a_r, b_r;
  logic [RW-1:0]     p0_r, p1_r;
  logic [RW-1:0]     res_r;
  logic [RW-1:0]     n0, n1;
  logic              eq;
  logic              step_op;

  logic [DATA_W-1:0] in_a, in_b;
  logic              in_op;
  logic              in_zero;
  logic              accept;
  logic              running;
  logic              unused_hi;

  assign in_a      = wd_in[A_LSB +: DATA_W];
  assign in_b      = wd_in[b_lsb(DATA_W) +: DATA_W];
  assign in_op     = wd_in[op_bit(DATA_W)];
  assign unused_hi = ^wd_in[WORD_W-1:op_bit(DATA_W)+1];
  assign in_zero   = (in_a == '0) || (in_b == '0);
  assign accept    = (state == IDLE) && start;
  assign running   = (state == RUN_GCD) || (state == RUN_LCM);
  assign step_op   = (state == RUN_LCM) ? OP_LCM : OP_GCD;

  gcd_lcm_step #(.DATA_W(DATA_W)) u_step (
    .op (step_op),
    .p0 (p0_r),
    .p1 (p1_r),
    .a  ({{DATA_W{1'b0}}, a_r}),
    .b  ({{DATA_W{1'b0}}, b_r}),
    .n0 (n0),
    .n1 (n1),
    .eq (eq)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (in_zero)              state_nxt = DONE;
          else if (in_op == OP_LCM) state_nxt = RUN_LCM;
          else                      state_nxt = RUN_GCD;
        end
      end
      RUN_GCD, RUN_LCM: if (eq) state_nxt = DONE;
      DONE:             state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Zero-operand ops resolve on the accept edge, which is also their DONE entry edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r   <= '0;
      b_r   <= '0;
      p0_r  <= '0;
      p1_r  <= '0;
      res_r <= '0;
    end else if (accept) begin
      a_r  <= in_a;
      b_r  <= in_b;
      p0_r <= {{DATA_W{1'b0}}, in_a};
      p1_r <= {{DATA_W{1'b0}}, in_b};
      if (in_zero)
        res_r <= (in_op == OP_LCM) ? '0 : {{DATA_W{1'b0}}, in_a | in_b};
    end else if (running) begin
      if (eq) begin
        res_r <= p0_r;
      end else begin
        p0_r <= n0;
        p1_r <= n1;
      end
    end
  end

  assign result = {{(WORD_W-RW){1'b0}}, res_r};

`ifdef GCD_LCM_CYCLE_COUNT_EN
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] cycles_r;

  // The equality step is itself a RUN cycle, so the reported count is run_cnt + 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt  <= '0;
      cycles_r <= '0;
    end else if (accept) begin
      run_cnt <= '0;
      if (in_zero) cycles_r <= '0;
    end else if (running) begin
      if (eq) cycles_r <= sat_inc(run_cnt);
      else    run_cnt  <= sat_inc(run_cnt);
    end
  end

  assign cycles = cycles_r;
`endif

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Self-checking bench for gcd_lcm_coproc: vector table, hand sequences and random ops
// against an arithmetic (Euclid / a*b/gcd) reference model.
module tb_gcd_lcm_coproc;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] wd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
`ifdef GCD_LCM_CYCLE_COUNT_EN
  logic [15:0] cycles;
`endif

  int checks = 0;
  int errors = 0;

  gcd_lcm_coproc #(.DATA_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .wd_in   (wd_in),
    .busy    (busy),
    .done    (done),
    .result  (result)
`ifdef GCD_LCM_CYCLE_COUNT_EN
    ,
    .cycles  (cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned a;
    int unsigned b;
    bit          op;
    int unsigned exp_res;
    int unsigned exp_steps;
    string       name;
  } vec_t;

  function automatic int unsigned m_gcd(input int unsigned a, input int unsigned b);
    int unsigned t;
    if (a == 0 || b == 0) return a | b;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int unsigned m_res(input int unsigned a, input int unsigned b, input bit op);
    if (a == 0 || b == 0) return op ? 0 : (a | b);
    return op ? (a * b) / m_gcd(a, b) : m_gcd(a, b);
  endfunction

  // Subtractive GCD takes sum-of-Euclid-quotients steps; additive LCM takes L/a + L/b - 1.
  function automatic int unsigned m_steps(input int unsigned a, input int unsigned b, input bit op);
    int unsigned l, s, t;
    if (a == 0 || b == 0) return 0;
    if (op) begin
      l = (a * b) / m_gcd(a, b);
      return l / a + l / b - 1;
    end
    s = 0;
    while (b != 0) begin
      s += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return s;
  endfunction

  function automatic logic [31:0] pack(input int unsigned a, input int unsigned b, input bit op);
    logic [7:0] av, bv;
    av = a[7:0];
    bv = b[7:0];
    return {15'b0, op, bv, av};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // Waits from just after the accept edge until done; returns elapsed edges.
  task automatic wait_done(input string name, output int unsigned n);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (done !== 1'b1) check({name, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input int unsigned a, input int unsigned b, input bit op,
                        input int unsigned exp_res, input int unsigned exp_steps,
                        input string name);
    int unsigned n;
    @(negedge clk);
    start = 1'b1;
    wd_in = pack(a, b, op);
    @(posedge clk); #1;
    start = 1'b0;
    wd_in = $urandom;
    wait_done(name, n);
    check({name, " latency"}, n, exp_steps);
    check({name, " result"}, result, exp_res);
    check({name, " busy in done"}, {31'b0, busy}, 32'd1);
`ifdef GCD_LCM_CYCLE_COUNT_EN
    check({name, " cycles"}, {16'b0, cycles}, exp_steps);
`endif
    @(posedge clk); #1;
    check({name, " done width"}, {31'b0, done}, 32'd0);
    check({name, " busy after"}, {31'b0, busy}, 32'd0);
    check({name, " result hold"}, result, exp_res);
  endtask

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, a, b;
    bit op;

    vecs.push_back('{12, 18, 1'b0, 6,     3,   "gcd_12_18"});
    vecs.push_back('{4,  6,  1'b1, 12,    4,   "lcm_4_6"});
    vecs.push_back('{0,  9,  1'b0, 9,     0,   "gcd_0_9"});
    vecs.push_back('{0,  0,  1'b0, 0,     0,   "gcd_0_0"});
    vecs.push_back('{0,  7,  1'b1, 0,     0,   "lcm_0_7"});
    vecs.push_back('{9,  0,  1'b1, 0,     0,   "lcm_9_0"});
    vecs.push_back('{255, 254, 1'b1, 64770, 508, "lcm_255_254"});
    vecs.push_back('{255, 1, 1'b0, 1,     255, "gcd_255_1"});
    vecs.push_back('{8,  12, 1'b0, 4,     3,   "gcd_8_12"});
    vecs.push_back('{7,  7,  1'b1, 7,     1,   "lcm_7_7"});

    reset_n = 1'b0;
    start   = 1'b0;
    wd_in   = '0;
    #12;
    check("reset busy",   {31'b0, busy}, 32'd0);
    check("reset done",   {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
`ifdef GCD_LCM_CYCLE_COUNT_EN
    check("reset cycles", {16'b0, cycles}, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_res, vecs[i].exp_steps, vecs[i].name);

    // start held high with churning wd_in; only the IDLE-accepted op may run.
    @(negedge clk);
    start = 1'b1;
    wd_in = pack(12, 18, 1'b0);
    @(posedge clk); #1;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      wd_in = pack($urandom_range(1, 255), $urandom_range(1, 255), 1'b1);
      @(posedge clk); #1;
      n++;
    end
    check("held latency", n, 3);
    check("held result", result, 6);
    wd_in = pack(8, 12, 1'b0);
    @(posedge clk); #1;
    check("held back to idle", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    check("held reaccept busy", {31'b0, busy}, 32'd1);
    check("held reaccept no done", {31'b0, done}, 32'd0);
    start = 1'b0;
    wait_done("held second", n);
    check("held second latency", n, 3);
    check("held second result", result, 4);
    @(posedge clk); #1;

    // Reset in the middle of a long LCM aborts it without a done pulse.
    @(negedge clk);
    start = 1'b1;
    wd_in = pack(255, 254, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check("abort no early done", n, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    check("abort result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("abort still idle", {31'b0, busy}, 32'd0);
    reset_n = 1'b1;
    run_op(8, 12, 1'b0, 4, 3, "post_reset_gcd");

    for (int i = 0; i < 40; i++) begin
      a  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
      b  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
      op = 1'($urandom_range(0, 1));
      run_op(a, b, op, m_res(a, b, op), m_steps(a, b, op), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
